// File: rtl/rom_boot_loader.sv
// Boot loader: receives a length-prefixed big-endian word stream and writes it into
// instruction memory from address 0, holding the CPU in reset until the image is complete.
module rom_boot_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  load_start,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [15:0]           rom_in,
  output logic                  rom_load,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // Byte source handshake: rx_valid is a one-cycle strobe with no ready/backpressure;
  // every strobe seen in LEN_HI..DATA_LO is consumed on that clock edge, strobes in DONE are dropped.

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  state_t                state;
  state_t                state_next;
  logic [7:0]            len_hi;
  logic [7:0]            hi_byte;
  logic [15:0]           remain;
  logic [ADDR_WIDTH:0]   wr_count;

  always_ff @(posedge clk) begin
    if (reset) state <= S_LEN_HI;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LEN_HI:  if (rx_valid) state_next = S_LEN_LO;
      S_LEN_LO:  if (rx_valid) state_next = ({len_hi, rx_data} == 16'd0) ? S_DONE : S_DATA_HI;
      S_DATA_HI: if (rx_valid) state_next = S_DATA_LO;
      S_DATA_LO: if (rx_valid) state_next = (remain == 16'd1) ? S_DONE : S_DATA_HI;
      S_DONE:    if (load_start) state_next = S_LEN_HI;
      default:   state_next = S_LEN_HI;
    endcase
  end

  // wr_count saturates at DEPTH (its top bit set) so oversized images keep being
  // consumed without wrapping onto low addresses; remain alone decides when to finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi      <= '0;
      hi_byte     <= '0;
      remain      <= '0;
      wr_count    <= '0;
      rom_address <= '0;
      rom_in      <= '0;
      rom_load    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rom_load <= 1'b0;
      case (state)
        S_LEN_HI: if (rx_valid) len_hi <= rx_data;
        S_LEN_LO: if (rx_valid) begin
          remain   <= {len_hi, rx_data};
          wr_count <= '0;
          if ({1'b0, len_hi, rx_data} > DEPTH) overflow <= 1'b1;
        end
        S_DATA_HI: if (rx_valid) hi_byte <= rx_data;
        S_DATA_LO: if (rx_valid) begin
          rom_in      <= {hi_byte, rx_data};
          rom_address <= wr_count[ADDR_WIDTH-1:0];
          rom_load    <= ~wr_count[ADDR_WIDTH];
          if (!wr_count[ADDR_WIDTH]) wr_count <= wr_count + 1'b1;
          remain      <= remain - 16'd1;
        end
        S_DONE: if (load_start) overflow <= 1'b0;
        default: ;
      endcase
    end
  end

  assign done      = (state == S_DONE);
  assign cpu_reset = ~done;
  assign busy      = ~done;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: a full-size instance and a 4-word instance share one stimulus
// stream; a write scoreboard built from the stream format checks the selected instance.
module tb_rom_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        load_start;

  logic [14:0] addr_b;
  logic [15:0] in_b;
  logic        load_b, cpur_b, busy_b, done_b, ovf_b;
  logic [1:0]  addr_s;
  logic [15:0] in_s;
  logic        load_s, cpur_s, busy_s, done_s, ovf_s;

  always #5 clk = ~clk;

  rom_boot_loader #(.ADDR_WIDTH(15)) dut_big (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .load_start(load_start),
    .rom_address(addr_b), .rom_in(in_b), .rom_load(load_b), .cpu_reset(cpur_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b)
  );

  rom_boot_loader #(.ADDR_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .load_start(load_start),
    .rom_address(addr_s), .rom_in(in_s), .rom_load(load_s), .cpu_reset(cpur_s),
    .busy(busy_s), .done(done_s), .overflow(ovf_s)
  );

  logic        sel = 1'b0;
  logic [14:0] o_addr;
  logic [15:0] o_in;
  logic        o_load, o_cpur, o_busy, o_done, o_ovf;

  always_comb begin
    o_addr = sel ? {13'd0, addr_s} : addr_b;
    o_in   = sel ? in_s   : in_b;
    o_load = sel ? load_s : load_b;
    o_cpur = sel ? cpur_s : cpur_b;
    o_busy = sel ? busy_s : busy_b;
    o_done = sel ? done_s : done_b;
    o_ovf  = sel ? ovf_s  : ovf_b;
  end

  int          checks = 0;
  int          errors = 0;
  int          load_cycles = 0;
  bit          rand_ls = 1'b1;
  logic [30:0] exp_q[$];
  logic [15:0] img[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every rom_load must match the oldest expected {address, data}.
  always @(negedge clk) begin
    if (o_load === 1'b1) begin
      load_cycles++;
      if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
      else check("write", {1'b0, o_addr, o_in}, {1'b0, exp_q.pop_front()});
    end
  end

  function automatic int pick_gap(input int g);
    return (g < 0) ? int'($urandom_range(0, 2)) : g;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid   = 1'b1;
    rx_data    = b;
    load_start = rand_ls ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      rx_valid   = 1'b0;
      rx_data    = 8'($urandom);
      load_start = rand_ls ? 1'($urandom_range(0, 1)) : 1'b0;
      check("busy_gap", {31'd0, o_busy}, 32'd1);
    end
  endtask

  // Reference model: word i of an N-word image lands at address i if i < depth.
  task automatic load_image(input int n, input int gap);
    int          dep;
    logic [15:0] nn;
    dep = sel ? 4 : 32768;
    nn  = n[15:0];
    for (int i = 0; i < n; i++)
      if (i < dep) exp_q.push_back({15'(i), img[i]});
    send(nn[15:8], pick_gap(gap));
    send(nn[7:0], (n == 0) ? 0 : pick_gap(gap));
    for (int i = 0; i < n; i++) begin
      send(img[i][15:8], pick_gap(gap));
      send(img[i][7:0], (i == n - 1) ? 0 : pick_gap(gap));
    end
    @(negedge clk);
    rx_valid   = 1'b0;
    load_start = 1'b0;
    check("last_load", {31'd0, o_load}, (n > 0 && n <= dep) ? 32'd1 : 32'd0);
    check("done_after_image", {31'd0, o_done}, 32'd1);
    check("cpu_reset_after_image", {31'd0, o_cpur}, 32'd0);
    check("busy_after_image", {31'd0, o_busy}, 32'd0);
    check("overflow_after_image", {31'd0, o_ovf}, (n > dep) ? 32'd1 : 32'd0);
    repeat (2) @(negedge clk);
    check("writes_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_rom_load", {31'd0, o_load}, 32'd0);
    check("rst_rom_address", {17'd0, o_addr}, 32'd0);
    check("rst_rom_in", {16'd0, o_in}, 32'd0);
    check("rst_cpu_reset", {31'd0, o_cpur}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd1);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_overflow", {31'd0, o_ovf}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset      = 1'b1;
    rx_valid   = 1'b0;
    load_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    load_cycles = 0;
    check_reset_values();
  endtask

  task automatic restart();
    @(negedge clk);
    load_start = 1'b1;
    rx_valid   = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    check("restart_cpu_reset", {31'd0, o_cpur}, 32'd1);
    check("restart_busy", {31'd0, o_busy}, 32'd1);
    check("restart_overflow", {31'd0, o_ovf}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    load_start = 1'b0;

    // Two back-to-back words.
    apply_reset();
    img = '{16'h1234, 16'hABCD};
    load_image(2, 0);
    check("two_word_load_cycles", load_cycles, 32'd2);

    // Empty image goes straight to DONE with no writes.
    apply_reset();
    img.delete();
    load_image(0, 0);
    check("empty_load_cycles", load_cycles, 32'd0);

    // Single word with long idle gaps between bytes.
    restart();
    img = '{16'hBEEF};
    load_image(1, 5);

    // Reset in the middle of a three-word image.
    apply_reset();
    exp_q.push_back({15'd0, 16'h1122});
    send(8'h00, 0);
    send(8'h03, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    @(negedge clk);
    rx_valid   = 1'b0;
    load_start = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    check("midload_write_count", load_cycles, 32'd1);
    check("midload_drained", exp_q.size(), 32'd0);
    apply_reset();
    repeat (3) @(negedge clk);
    check("no_write_after_reset", load_cycles, 32'd0);
    img = '{16'h4455};
    load_image(1, 0);

    // Bytes in DONE are ignored; load_start with a byte re-arms and drops that byte.
    rand_ls = 1'b0;
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("done_ignores_bytes", {31'd0, o_done}, 32'd1);
    @(negedge clk);
    load_start = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = 8'h00;
    @(negedge clk);
    load_start = 1'b0;
    rx_valid   = 1'b0;
    check("rearm_cpu_reset", {31'd0, o_cpur}, 32'd1);
    check("rearm_busy", {31'd0, o_busy}, 32'd1);
    check("rearm_done", {31'd0, o_done}, 32'd0);
    img = '{16'h0007};
    load_image(1, 0);
    rand_ls = 1'b1;

    // Oversized image on the 4-word instance.
    sel = 1'b1;
    apply_reset();
    img.delete();
    for (int i = 0; i < 5; i++) img.push_back(16'($urandom));
    load_image(5, -1);
    check("overflow_write_count", load_cycles, 32'd4);
    restart();
    img.delete();
    for (int i = 0; i < 3; i++) img.push_back(16'($urandom));
    load_image(3, -1);

    // Random images on the full-size instance.
    sel = 1'b0;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 6));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
      load_image(n, -1);
      restart();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
